demux_reg: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshakes: routes a WIDTH-bit word from one upstream producer to one of two downstream consumers, chosen per word by a select bit. It is the distribution counterpart of the datapath 2:1 selector. It sits wherever one result bus fans out to two sinks, such as the write-back and store paths. Each output has a one-entry holding register, so a stalled sink never corrupts the other path. Per-output delivery counters support debug.

---
 rtl/demux_reg_if.sv | 42 ++++
 rtl/demux_reg.sv | 62 ++++++
 tb/tb_demux_reg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/demux_reg_if.sv
// Handshake bundle for demux_reg: one producer port, two sink ports and the
// per-sink delivery counters.
interface demux_reg_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_data, in_select, in_valid,
        output in_ready,
        output out0_data, out0_valid,
        input  out0_ready,
        output out1_data, out1_valid,
        input  out1_ready,
        output cnt0, cnt1
    );

    modport master (
        output in_data, in_select, in_valid,
        input  in_ready,
        input  out0_data, out0_valid,
        output out0_ready,
        input  out1_data, out1_valid,
        output out1_ready,
        input  cnt0, cnt1
    );
endinterface

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer: each sink owns a one-entry holding slot so a
// stalled sink never blocks words headed for the other one.
module demux_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    demux_reg_if.slave bus
);
    logic [1:0]       v;
    logic [1:0]       out_ready;
    logic [1:0]       free;
    logic [1:0]       accept;
    logic [1:0]       take;
    logic             in_ready;
    logic [WIDTH-1:0] data [2];
    logic [CNT_W-1:0] cnt  [2];

    // A slot is free when empty or draining, so a full slot can refill without a bubble.
    always_comb begin
        out_ready = {bus.out1_ready, bus.out0_ready};
        free      = ~v | out_ready;
        in_ready  = bus.in_select ? free[1] : free[0];
        take      = v & out_ready;
        accept    = 2'b00;
        if (bus.in_valid && in_ready) begin
            accept[bus.in_select] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                data[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (accept[k]) begin
                    data[k] <= bus.in_data;
                    v[k]    <= 1'b1;
                end else if (take[k]) begin
                    v[k]    <= 1'b0;
                end
                // Deliveries count even when a new word lands in the same cycle.
                if (take[k]) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_data  = data[0];
    assign bus.out0_valid = v[0];
    assign bus.out1_data  = data[1];
    assign bus.out1_valid = v[1];
    assign bus.cnt0       = cnt[0];
    assign bus.cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: reset, routing, stall isolation, streaming,
// refill-while-draining and counter wrap, with hand-computed expectations.
module tb_demux_reg;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    demux_reg_if #(.WIDTH(16), .CNT_W(8)) bus ();

    demux_reg #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic sel, input logic [15:0] word);
        bus.in_valid  = valid;
        bus.in_select = sel;
        bus.in_data   = word;
    endtask

    // One rising edge, then settle on the falling edge where all sampling happens.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        check_output("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check_output("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check_output("rst_out0_data", 32'(bus.out0_data), 32'h0);
        check_output("rst_cnt0", 32'(bus.cnt0), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic route
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 16'h1234);
        #1 check_output("route_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("route_out0_valid", 32'(bus.out0_valid), 32'd1);
        check_output("route_out0_data", 32'(bus.out0_data), 32'h1234);
        apply_stimulus(1'b1, 1'b1, 16'hABCD);
        tick();
        check_output("route_out1_valid", 32'(bus.out1_valid), 32'd1);
        check_output("route_out1_data", 32'(bus.out1_data), 32'hABCD);
        check_output("route_out0_empty", 32'(bus.out0_valid), 32'd0);
        check_output("route_cnt0", 32'(bus.cnt0), 32'd1);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("route_cnt1", 32'(bus.cnt1), 32'd1);
        check_output("route_out1_empty", 32'(bus.out1_valid), 32'd0);

        // Stall isolation
        bus.out0_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 16'h0001);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'h0002);
        #1 check_output("stall_in_ready_sel0", 32'(bus.in_ready), 32'd0);
        tick();
        check_output("stall_out0_data", 32'(bus.out0_data), 32'h0001);
        check_output("stall_out0_valid", 32'(bus.out0_valid), 32'd1);
        apply_stimulus(1'b1, 1'b1, 16'h0003);
        #1 check_output("stall_in_ready_sel1", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("stall_out1_data", 32'(bus.out1_data), 32'h0003);
        check_output("stall_out1_valid", 32'(bus.out1_valid), 32'd1);
        check_output("stall_out0_hold", 32'(bus.out0_data), 32'h0001);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("stall_cnt1", 32'(bus.cnt1), 32'd2);
        check_output("stall_cnt0_frozen", 32'(bus.cnt0), 32'd1);
        bus.out0_ready = 1'b1;
        tick();
        check_output("stall_release_cnt0", 32'(bus.cnt0), 32'd2);
        check_output("stall_release_empty", 32'(bus.out0_valid), 32'd0);

        // Streaming: ten words back-to-back, cnt0 goes 2 -> 12
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'h0010 + 16'(i));
            #1 check_output("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            check_output("stream_out0_valid", 32'(bus.out0_valid), 32'd1);
            check_output("stream_out0_data", 32'(bus.out0_data), 32'h0010 + 32'(i));
        end
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("stream_cnt0", 32'(bus.cnt0), 32'd12);
        tick();
        check_output("idle_ready_not_counted", 32'(bus.cnt0), 32'd12);

        // Accept into a slot that drains in the same cycle
        bus.out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b1, 16'h00AA);
        tick();
        check_output("simul_hold_aa", 32'(bus.out1_data), 32'h00AA);
        bus.out1_ready = 1'b1;
        apply_stimulus(1'b1, 1'b1, 16'h00BB);
        #1 check_output("simul_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("simul_out1_data", 32'(bus.out1_data), 32'h00BB);
        check_output("simul_out1_valid", 32'(bus.out1_valid), 32'd1);
        check_output("simul_cnt1", 32'(bus.cnt1), 32'd3);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("simul_drain_cnt1", 32'(bus.cnt1), 32'd4);

        // Counter wrap: 243 more words bring cnt0 from 12 to 255, one more wraps to 0
        for (int i = 0; i < 243; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'(i));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("wrap_cnt0_255", 32'(bus.cnt0), 32'd255);
        apply_stimulus(1'b1, 1'b0, 16'h5555);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick();
        check_output("wrap_cnt0_0", 32'(bus.cnt0), 32'd0);
        check_output("wrap_cnt1_same", 32'(bus.cnt1), 32'd4);

        // Asynchronous reset mid-cycle while slot 1 holds a word
        bus.out1_ready = 1'b0;
        apply_stimulus(1'b1, 1'b1, 16'hBEEF);
        tick();
        apply_stimulus(1'b0, 1'b1, 16'h0000);
        check_output("areset_pre_data", 32'(bus.out1_data), 32'hBEEF);
        #2 rst_n = 1'b0;
        #1;
        check_output("areset_out1_valid", 32'(bus.out1_valid), 32'd0);
        check_output("areset_out1_data", 32'(bus.out1_data), 32'h0);
        check_output("areset_cnt1", 32'(bus.cnt1), 32'd0);
        check_output("areset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_output("areset_post_cnt1", 32'(bus.cnt1), 32'd0);
        check_output("areset_post_valid", 32'(bus.out1_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
